rho_phase_argmax: RTL and testbench
===================================

Name: rho_phase_argmax

Overview:
Parametrised successor of the fixed 16-angle right-lane ρ/phase selector. It takes a packed vector of NUM_PHASE ρ values per pixel from the upstream rho_cacl array and keeps a running per-phase ρ maximum over a programmable window of valid samples. It then reduces the window maxima through a pipelined argmax tree and reports the winning ρ and its phase in image-angle convention (180 − θ) for either lane half. It sits between the rho_cacl array and the lane-line drawing logic.

Parameters:
NUM_PHASE, 16, number of candidate angles (2..64; non-power-of-two allowed)
RHO_W, 28, unsigned width of each ρ value
PHASE_START, 10, first candidate angle θ0 in degrees (right half)
PHASE_STEP, 5, angle increment in degrees between candidates
WIN_LEN, 256, valid samples per accumulation window (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
sof  in  1  frame/window restart pulse; synchronous clear of window state
interest_part  in  1  0 = left half, 1 = right half; latched at window completion
in_vld  in  1  rho_vec valid strobe
rho_vec  in  NUM_PHASE*RHO_W  packed ρ values; slice i = phase index i
out_vld  out  1  one-cycle pulse when a window result is ready
phase_idx  out  clog2(NUM_PHASE)  winning phase index
phase_data  out  8  180 − winning θ in degrees
rho_data  out  RHO_W  winning ρ

Behaviour:
- Reset: all outputs 0; sample counter, accumulators, tree stages and valid pipe are cleared. Reset mid-window or mid-tree discards all in-flight results, and no out_vld follows.
- Window counter cnt (0..WIN_LEN−1) advances on each in_vld and wraps to 0 after WIN_LEN−1.
- On in_vld: if cnt==0, acc[i] <= rho[i]; otherwise acc[i] <= max(acc[i], rho[i]). Comparison is unsigned.
- On the in_vld with cnt==WIN_LEN−1, the final maxima and interest_part are snapshotted into tree stage 0 on the next edge. The accumulators restart with the next sample.
- sof: cnt <= 0 and the current partial window is dropped. If sof and in_vld occur in the same cycle, that sample is the first sample of the new window. sof does not affect windows already in the tree.
- Argmax tree: STAGES = clog2(NUM_PHASE) registered pairwise stages. Each stage carries {index, ρ}.
  - Ties go to the lower index (left operand ≥ right wins).
  - Non-power-of-two NUM_PHASE is padded with entries {ρ=0, index beyond range}. Padding never wins.
- Latency: out_vld rises exactly STAGES+2 cycles after the clock edge that samples the last in_vld of a window (6 for NUM_PHASE=16).
- The pipeline is fully pipelined. With WIN_LEN=1, every in_vld produces an out_vld; there is no backpressure.
- Phase mapping, computed in the output register with θ = PHASE_START + idx*PHASE_STEP:
  - right half: phase_data = 180 − θ
  - left half: phase_data = 180 − (θ + 90)
  - Arithmetic is 9-bit intermediate, truncated to 8 bits. Parameters must keep the result in 0..180.
- Outputs phase_idx, phase_data and rho_data update only when out_vld is asserted and hold otherwise.

Decomposition:
- Package hough_pkg holds:
  - an rho_t typedef parameterised on RHO_W
  - a phase_idx_t typedef
  - a {idx, rho} candidate struct
  - ANGLE_SPLIT_DEG=90 and ANGLE_FULL_DEG=180 constants
  - a clog2-based STAGES function
- One sub-module, argmax_tree: pipelined, parameterised on N and RHO_W, handling padding and tie-break. It is reused by the future left/right joint selector.

Test Plan:
- Defaults, right half, one window of 256 samples where only phase 7 (45°) ever reaches ρ=1000 and all other phases stay ≤999 -> a single out_vld 6 cycles after the last in_vld, with idx=7, phase_data=135, rho_data=1000.
- Left half (interest_part=0 at window end), phase 0 holds max ρ=50 -> idx=0, phase_data=80. Repeat with phase 15 winning -> phase_data=5.
- Tie: phases 3 and 12 both reach ρ=0xFFFFFFF (RHO_W max), others lower -> idx=3, rho_data=0xFFFFFFF.
- WIN_LEN=1, NUM_PHASE=5: back-to-back in_vld with winners 4, 0, 2 -> consecutive out_vld pulses in the same order, 5 cycles after each input (STAGES=3). Padding never selected, including an all-zero vector -> idx=0.
- sof asserted after 100 samples of a 256-sample window, with a pre-sof spike ρ=9999 on phase 2 -> the spike is absent from the result. The next out_vld comes only after 256 post-sof samples, with sof+in_vld in the same cycle counting as sample 1.
- rst_n pulsed low 2 cycles after the last sample of a window -> no out_vld afterwards and all outputs are 0. Normal operation resumes on the next full window.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared types, angle constants and helpers for the Hough rho/phase selection path.
package hough_pkg;

  localparam int RHO_W_DEF       = 28;
  localparam int NUM_PHASE_DEF   = 16;
  localparam int ANGLE_SPLIT_DEG = 90;
  localparam int ANGLE_FULL_DEG  = 180;

  typedef logic [RHO_W_DEF-1:0]             rho_t;
  typedef logic [$clog2(NUM_PHASE_DEF)-1:0] phase_idx_t;

  typedef struct packed {
    phase_idx_t idx;
    rho_t       rho;
  } cand_t;

  function automatic int stages(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Image-angle convention: 180 - theta, left half shifted by 90 degrees.
  // 9-bit intermediate, truncated to 8 bits.
  function automatic logic [7:0] phase_deg(input int idx, input logic right,
                                           input int start, input int step);
    logic [8:0] theta;
    theta = 9'(start + idx * step);
    if (!right) theta = theta + 9'(ANGLE_SPLIT_DEG);
    return 8'(9'(ANGLE_FULL_DEG) - theta);
  endfunction

endpackage

// File: rtl/argmax_tree.sv
// Pipelined argmax over N unsigned values: one leaf register stage, then
// clog2(N) pairwise stages. Lower index wins ties; padding leaves never win.
module argmax_tree
  import hough_pkg::*;
#(
  parameter int N     = 16,
  parameter int RHO_W = 28,
  parameter int TAG_W = 1,
  localparam int STG  = stages(N),
  localparam int IW   = (STG < 1) ? 1 : STG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [N*RHO_W-1:0] in_rho,
  output logic               out_vld,
  output logic [TAG_W-1:0]   out_tag,
  output logic [IW-1:0]      out_idx,
  output logic [RHO_W-1:0]   out_rho
);

  localparam int N2    = 1 << STG;
  localparam int NODES = 2 * N2 - 1;

  // Heap layout: node 0 is the root, leaves sit at N2-1 .. 2*N2-2.
  logic [IW-1:0]    node_idx [NODES];
  logic [RHO_W-1:0] node_rho [NODES];
  logic [STG:0]     vld_q;
  logic [TAG_W-1:0] tag_q [STG+1];

  genvar gi;
  generate
    for (gi = 0; gi < N2; gi++) begin : g_leaf
      if (gi < N) begin : g_real
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            node_idx[N2-1+gi] <= '0;
            node_rho[N2-1+gi] <= '0;
          end else begin
            node_idx[N2-1+gi] <= IW'(gi);
            node_rho[N2-1+gi] <= in_rho[gi*RHO_W +: RHO_W];
          end
        end
      end else begin : g_pad
        // Out-of-range index with zero rho always sits right of every real leaf.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            node_idx[N2-1+gi] <= '0;
            node_rho[N2-1+gi] <= '0;
          end else begin
            node_idx[N2-1+gi] <= IW'(gi);
            node_rho[N2-1+gi] <= '0;
          end
        end
      end
    end

    for (gi = 0; gi < N2 - 1; gi++) begin : g_node
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          node_idx[gi] <= '0;
          node_rho[gi] <= '0;
        end else if (node_rho[2*gi+1] >= node_rho[2*gi+2]) begin
          node_idx[gi] <= node_idx[2*gi+1];
          node_rho[gi] <= node_rho[2*gi+1];
        end else begin
          node_idx[gi] <= node_idx[2*gi+2];
          node_rho[gi] <= node_rho[2*gi+2];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s <= STG; s++) tag_q[s] <= '0;
    end else begin
      vld_q    <= {vld_q[STG-1:0], in_vld};
      tag_q[0] <= in_tag;
      for (int s = 1; s <= STG; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign out_vld = vld_q[STG];
  assign out_tag = tag_q[STG];
  assign out_idx = node_idx[0];
  assign out_rho = node_rho[0];

endmodule

// File: rtl/rho_phase_argmax.sv
// Windowed per-phase rho maximum followed by a pipelined argmax; reports the
// winning rho and its image-angle phase for the selected lane half.
module rho_phase_argmax
  import hough_pkg::*;
#(
  parameter int NUM_PHASE   = 16,
  parameter int RHO_W       = 28,
  parameter int PHASE_START = 10,
  parameter int PHASE_STEP  = 5,
  parameter int WIN_LEN     = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sof,
  input  logic                         interest_part,
  input  logic                         in_vld,
  input  logic [NUM_PHASE*RHO_W-1:0]   rho_vec,
  output logic                         out_vld,
  output logic [$clog2(NUM_PHASE)-1:0] phase_idx,
  output logic [7:0]                   phase_data,
  output logic [RHO_W-1:0]             rho_data
);

  localparam int IW = $clog2(NUM_PHASE);
  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIN_LEN - 1);

  logic [CW-1:0]              cnt_reg;
  logic [CW-1:0]              cnt_eff;
  logic                       win_last;
  logic                       done_reg;
  logic                       part_reg;
  logic [RHO_W-1:0]           acc_reg [NUM_PHASE];
  logic [NUM_PHASE*RHO_W-1:0] acc_flat;

  logic             tree_vld;
  logic             tree_part;
  logic [IW-1:0]    tree_idx;
  logic [RHO_W-1:0] tree_rho;

  // sof restarts the window; a sample in the same cycle becomes sample 1.
  assign cnt_eff  = sof ? '0 : cnt_reg;
  assign win_last = in_vld && (cnt_eff == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
      part_reg <= 1'b0;
    end else begin
      if (in_vld)   cnt_reg <= win_last ? '0 : cnt_eff + 1'b1;
      else if (sof) cnt_reg <= '0;
      done_reg <= win_last;
      if (win_last) part_reg <= interest_part;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASE; gi++) begin : g_acc
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg[gi] <= '0;
        end else if (in_vld) begin
          if ((cnt_eff == '0) || (rho_vec[gi*RHO_W +: RHO_W] > acc_reg[gi]))
            acc_reg[gi] <= rho_vec[gi*RHO_W +: RHO_W];
        end
      end
      assign acc_flat[gi*RHO_W +: RHO_W] = acc_reg[gi];
    end
  endgenerate

  // Leaf stage of the tree snapshots the final maxima one edge after completion.
  argmax_tree #(
    .N     (NUM_PHASE),
    .RHO_W (RHO_W),
    .TAG_W (1)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (done_reg),
    .in_tag  (part_reg),
    .in_rho  (acc_flat),
    .out_vld (tree_vld),
    .out_tag (tree_part),
    .out_idx (tree_idx),
    .out_rho (tree_rho)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld    <= 1'b0;
      phase_idx  <= '0;
      phase_data <= '0;
      rho_data   <= '0;
    end else begin
      out_vld <= tree_vld;
      if (tree_vld) begin
        phase_idx  <= tree_idx;
        rho_data   <= tree_rho;
        phase_data <= phase_deg(int'(tree_idx), tree_part, PHASE_START, PHASE_STEP);
      end
    end
  end

endmodule

// File: tb/tb_rho_phase_argmax.sv
// Bench for rho_phase_argmax: a default 16-phase/256-sample instance and a
// 5-phase/1-sample instance, checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_rho_phase_argmax;

  localparam int RW = 28;
  typedef logic [RW-1:0] r_t;
  typedef struct {
    int due;
    int idx;
    int ph;
    r_t rho;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sof_a, part_a, vld_a;
  logic [16*RW-1:0] vec_a;
  logic ovld_a;
  logic [3:0] idx_a;
  logic [7:0] pd_a;
  r_t rd_a;

  logic sof_b, part_b, vld_b;
  logic [5*RW-1:0] vec_b;
  logic ovld_b;
  logic [2:0] idx_b;
  logic [7:0] pd_b;
  r_t rd_b;

  rho_phase_argmax #(
    .NUM_PHASE(16), .RHO_W(RW), .PHASE_START(10), .PHASE_STEP(5), .WIN_LEN(256)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sof(sof_a), .interest_part(part_a), .in_vld(vld_a),
    .rho_vec(vec_a), .out_vld(ovld_a), .phase_idx(idx_a), .phase_data(pd_a), .rho_data(rd_a)
  );

  rho_phase_argmax #(
    .NUM_PHASE(5), .RHO_W(RW), .PHASE_START(10), .PHASE_STEP(5), .WIN_LEN(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sof(sof_b), .interest_part(part_b), .in_vld(vld_b),
    .rho_vec(vec_b), .out_vld(ovld_b), .phase_idx(idx_b), .phase_data(pd_b), .rho_data(rd_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  bit run = 1'b0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Model: per-window per-phase max, first-maximum argmax, angle formula.
  r_t   mx [2][16];
  int   cnt_m [2];
  exp_t qa[$];
  exp_t qb[$];
  exp_t hold_a, hold_b;

  task automatic model_sample(input int d, input r_t v[16], input logic part, input logic s);
    int n, w, best, th;
    exp_t e;
    n = (d == 0) ? 16 : 5;
    w = (d == 0) ? 256 : 1;
    if (s) cnt_m[d] = 0;
    for (int i = 0; i < n; i++)
      if (cnt_m[d] == 0 || v[i] > mx[d][i]) mx[d][i] = v[i];
    cnt_m[d]++;
    if (cnt_m[d] == w) begin
      cnt_m[d] = 0;
      best = 0;
      for (int i = 1; i < n; i++)
        if (mx[d][i] > mx[d][best]) best = i;
      th    = 10 + 5 * best;
      e.ph  = (part ? (180 - th) : (180 - (th + 90))) & 255;
      e.idx = best;
      e.rho = mx[d][best];
      e.due = cyc + 1 + ((d == 0) ? 4 : 3) + 2;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  function automatic void clear_model();
    qa.delete();
    qb.delete();
    hold_a.due = 0; hold_a.idx = 0; hold_a.ph = 0; hold_a.rho = '0;
    hold_b.due = 0; hold_b.idx = 0; hold_b.ph = 0; hold_b.rho = '0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        chk("a_out_vld", ovld_a, 1);
        chk("a_idx", idx_a, qa[0].idx);
        chk("a_phase", pd_a, qa[0].ph);
        chk("a_rho", rd_a, qa[0].rho);
        hold_a = qa.pop_front();
      end else begin
        chk("a_out_vld_idle", ovld_a, 0);
        chk("a_idx_hold", idx_a, hold_a.idx);
        chk("a_phase_hold", pd_a, hold_a.ph);
        chk("a_rho_hold", rd_a, hold_a.rho);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        chk("b_out_vld", ovld_b, 1);
        chk("b_idx", idx_b, qb[0].idx);
        chk("b_phase", pd_b, qb[0].ph);
        chk("b_rho", rd_b, qb[0].rho);
        hold_b = qb.pop_front();
      end else begin
        chk("b_out_vld_idle", ovld_b, 0);
        chk("b_idx_hold", idx_b, hold_b.idx);
        chk("b_phase_hold", pd_b, hold_b.ph);
        chk("b_rho_hold", rd_b, hold_b.rho);
      end
    end
  end

  task automatic send(input int d, input r_t v[16], input logic part, input logic s);
    @(posedge clk); #1;
    if (d == 0) begin
      vld_a = 1'b1; sof_a = s; part_a = part;
      for (int i = 0; i < 16; i++) vec_a[i*RW +: RW] = v[i];
      vld_b = 1'b0; sof_b = 1'b0;
    end else begin
      vld_b = 1'b1; sof_b = s; part_b = part;
      for (int i = 0; i < 5; i++) vec_b[i*RW +: RW] = v[i];
      vld_a = 1'b0; sof_a = 1'b0;
    end
    model_sample(d, v, part, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vld_a = 1'b0; vld_b = 1'b0; sof_a = 1'b0; sof_b = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; sof_a = 1'b0; sof_b = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  r_t v [16];

  initial begin
    rst_n = 1'b1;
    vld_a = 0; sof_a = 0; part_a = 0; vec_a = '0;
    vld_b = 0; sof_b = 0; part_b = 0; vec_b = '0;
    clear_model();
    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", ovld_a, 0);
    chk("rst_rho", rd_a, 0);
    chk("rst_phase", pd_a, 0);
    rst_n = 1'b1;

    // WIN_LEN=1, 5 phases: back-to-back winners 4, 0, 2
    v = '{default: '0};
    v[0] = 1; v[1] = 2; v[2] = 3; v[3] = 4; v[4] = 9;
    send(1, v, 1'b1, 1'b0);
    v[0] = 9; v[1] = 1; v[2] = 1; v[3] = 1; v[4] = 1;
    send(1, v, 1'b1, 1'b0);
    v[0] = 0; v[1] = 0; v[2] = 5; v[3] = 0; v[4] = 0;
    send(1, v, 1'b1, 1'b0);
    idle(8);
    chk("b_last_idx", idx_b, 2);
    chk("b_last_phase", pd_b, 160);
    chk("b_last_rho", rd_b, 5);
    v = '{default: '0};
    send(1, v, 1'b1, 1'b0);
    idle(8);
    chk("b_zero_idx", idx_b, 0);
    chk("b_zero_phase", pd_b, 170);

    // Right half, phase 7 alone reaches 1000
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) v[i] = r_t'((i * 37 + k * 13) % 1000);
      if (k == 100) v[7] = 1000;
      send(0, v, 1'b1, 1'b0);
    end
    idle(10);
    chk("t1_idx", idx_a, 7);
    chk("t1_phase", pd_a, 135);
    chk("t1_rho", rd_a, 1000);

    // Left half, phase 0 then phase 15 winning
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 256; k++) begin
        for (int i = 0; i < 16; i++) v[i] = r_t'((k + i) % 50);
        if (k == 5) v[(rep == 0) ? 0 : 15] = 50;
        send(0, v, 1'b0, 1'b0);
      end
      idle(10);
      chk("t2_idx", idx_a, (rep == 0) ? 0 : 15);
      chk("t2_phase", pd_a, (rep == 0) ? 80 : 5);
      chk("t2_rho", rd_a, 50);
    end

    // Tie at full scale between phases 3 and 12
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) v[i] = r_t'((k * 3 + i) % 1000);
      if (k == 20)  v[12] = 28'hFFFFFFF;
      if (k == 200) v[3]  = 28'hFFFFFFF;
      send(0, v, 1'b1, 1'b0);
    end
    idle(10);
    chk("t3_idx", idx_a, 3);
    chk("t3_rho", rd_a, 28'hFFFFFFF);
    chk("t3_phase", pd_a, 155);

    // sof after 100 samples drops the spike; sof+in_vld is sample 1
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 16; i++) v[i] = r_t'((k + i) % 100);
      if (k == 50) v[2] = 9999;
      send(0, v, 1'b1, 1'b0);
    end
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) v[i] = r_t'((k * 7 + i) % 500);
      if (k == 30) v[9] = 700;
      send(0, v, 1'b1, (k == 0));
    end
    idle(10);
    chk("t4_idx", idx_a, 9);
    chk("t4_rho", rd_a, 700);
    chk("t4_phase", pd_a, 125);

    // Reset two cycles after a window's last sample discards the result
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) v[i] = r_t'((i * 11 + k) % 800);
      send(0, v, 1'b1, 1'b0);
    end
    idle(2);
    do_reset();
    idle(10);
    chk("t5_out_vld", ovld_a, 0);
    chk("t5_idx", idx_a, 0);
    chk("t5_phase", pd_a, 0);
    chk("t5_rho", rd_a, 0);
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) v[i] = r_t'((i + k) % 300);
      if (k == 9) v[4] = 300;
      send(0, v, 1'b1, 1'b0);
    end
    idle(10);
    chk("t5_resume_idx", idx_a, 4);
    chk("t5_resume_phase", pd_a, 150);
    chk("t5_resume_rho", rd_a, 300);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
